// File: rtl/vproc_timer_target.sv
// vproc_timer_target
//   Bus responder for the VProc initiator port. It decodes a 4 KB register
//   window, acks reads and writes after a programmable number of wait states,
//   and holds a 32-bit down-counting timer plus software interrupt bits that
//   drive the VProc interrupt vector.
//
// Ports
//   Clk        clock, all state on the rising edge
//   nReset     asynchronous active-low reset
//   Addr       byte address from the initiator
//   WE         write request, held until WRAck is sampled
//   DataIn     write data from the initiator
//   RD         read request, held until RDAck is sampled
//   DataOut    read data; non-zero only in the RDAck cycle
//   WRAck      one-cycle write acknowledge
//   RDAck      one-cycle read acknowledge
//   Interrupt  [0] timer expiry & IE, [2:1] software interrupts (registered)
//
// Register map (offset = Addr[11:2])
//   0x000 CTRL   [0] EN, [1] RELOAD, [2] IE
//   0x004 LOAD   reload value; writing it also loads COUNT
//   0x008 COUNT  read-only current count
//   0x00C STATUS [0] EXPIRED, sticky, write 1 to clear
//   0x010 SWIRQ  [2:1] software interrupts, [0] reads 0
module vproc_timer_target #(
  parameter logic [31:0] BASE_ADDR = 32'h20000000,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned WR_WAIT   = 0
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  input  logic        RD,
  output logic [31:0] DataOut,
  output logic        WRAck,
  output logic        RDAck,
  output logic [2:0]  Interrupt
);

  localparam logic [3:0] RDW = 4'(RD_WAIT);
  localparam logic [3:0] WRW = 4'(WR_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wcnt;
  logic        kind_wr;
  logic [9:0]  offs;

  logic        ctrl_en, ctrl_rel, ctrl_ie;
  logic [31:0] load_r, count_r;
  logic        expired;
  logic [1:0]  swirq;

  logic        sel;
  logic [3:0]  req_wait;
  logic        enter_ack;
  logic        acc_wr;
  logic [9:0]  acc_off;
  logic        wr_en, rd_en;
  logic        expire, clr_exp;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^Addr[1:0];

  assign sel      = (WE | RD) && (Addr[31:12] == BASE_ADDR[31:12]);
  assign req_wait = WE ? WRW : RDW;

  // With zero wait states the commit edge is the sampling edge itself, so the
  // access kind/offset come straight from the bus instead of the latches.
  assign enter_ack = (state != S_ACK) && (state_nxt == S_ACK);
  assign acc_wr    = (state == S_IDLE) ? WE : kind_wr;
  assign acc_off   = (state == S_IDLE) ? Addr[11:2] : offs;
  assign wr_en     = enter_ack && acc_wr;
  assign rd_en     = enter_ack && !acc_wr;

  assign expire  = ctrl_en && (count_r == '0);
  assign clr_exp = wr_en && (acc_off == 10'd3) && DataIn[0];

  // State register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ACK always returns to IDLE without sampling requests
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (sel) state_nxt = (req_wait == '0) ? S_ACK : S_WAIT;
      S_WAIT: if (wcnt == 4'd1) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    WRAck = 1'b0;
    RDAck = 1'b0;
    if (state == S_ACK) begin
      WRAck = kind_wr;
      RDAck = !kind_wr;
    end
  end

  // Access latches and wait counter
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wcnt    <= '0;
      kind_wr <= 1'b0;
      offs    <= '0;
    end else if (state == S_IDLE && sel) begin
      wcnt    <= req_wait;
      kind_wr <= WE;
      offs    <= Addr[11:2];
    end else if (state == S_WAIT) begin
      wcnt    <= wcnt - 4'd1;
    end
  end

  // Read mux (values as they stand at the edge entering ACK)
  always_comb begin
    rdata = '0;
    unique case (acc_off)
      10'd0:   rdata = {29'd0, ctrl_ie, ctrl_rel, ctrl_en};
      10'd1:   rdata = load_r;
      10'd2:   rdata = count_r;
      10'd3:   rdata = {31'd0, expired};
      10'd4:   rdata = {29'd0, swirq, 1'b0};
      default: rdata = '0;
    endcase
  end

  // Timer and registers. Register writes follow the timer update so that a
  // bus write overrides the same-cycle reload or auto EN-clear; EXPIRED is
  // computed so a same-cycle expiry beats a clear.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ctrl_en  <= 1'b0;
      ctrl_rel <= 1'b0;
      ctrl_ie  <= 1'b0;
      load_r   <= '0;
      count_r  <= '0;
      expired  <= 1'b0;
      swirq    <= '0;
    end else begin
      if (ctrl_en) begin
        if (count_r != '0) begin
          count_r <= count_r - 32'd1;
        end else if (ctrl_rel) begin
          count_r <= load_r;
        end else begin
          ctrl_en <= 1'b0;
        end
      end
      expired <= (expired && !clr_exp) || expire;
      if (wr_en) begin
        unique case (acc_off)
          10'd0: begin
            ctrl_en  <= DataIn[0];
            ctrl_rel <= DataIn[1];
            ctrl_ie  <= DataIn[2];
          end
          10'd1: begin
            load_r  <= DataIn;
            count_r <= DataIn;
          end
          10'd4:   swirq <= DataIn[2:1];
          default: ;
        endcase
      end
    end
  end

  // Registered bus data and interrupt outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      DataOut   <= '0;
      Interrupt <= '0;
    end else begin
      DataOut   <= rd_en ? rdata : '0;
      Interrupt <= {swirq, expired && ctrl_ie};
    end
  end

endmodule

// File: tb/tb_vproc_timer_target.sv
module tb_vproc_timer_target;

  localparam int unsigned RDW = 1;
  localparam int unsigned WRW = 0;

  localparam logic [31:0] A_CTRL   = 32'h20000000;
  localparam logic [31:0] A_LOAD   = 32'h20000004;
  localparam logic [31:0] A_COUNT  = 32'h20000008;
  localparam logic [31:0] A_STATUS = 32'h2000000C;
  localparam logic [31:0] A_SWIRQ  = 32'h20000010;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [31:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] DataIn = '0;
  logic        RD = 1'b0;
  logic [31:0] DataOut;
  logic        WRAck, RDAck;
  logic [2:0]  Interrupt;

  always #5 Clk = ~Clk;

  vproc_timer_target #(
    .BASE_ADDR(32'h20000000),
    .RD_WAIT  (RDW),
    .WR_WAIT  (WRW)
  ) dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .Addr     (Addr),
    .WE       (WE),
    .DataIn   (DataIn),
    .RD       (RD),
    .DataOut  (DataOut),
    .WRAck    (WRAck),
    .RDAck    (RDAck),
    .Interrupt(Interrupt)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_wrack = 0;
  int n_rdack = 0;

  // Register-level model of the target
  bit          m_en, m_rel, m_ie, m_exp;
  logic [31:0] m_load, m_count;
  logic [1:0]  m_sw;
  logic [31:0] exp_dout = '0;
  logic        exp_wrack = 1'b0;
  logic        exp_rdack = 1'b0;
  logic [2:0]  exp_irq = '0;

  // Access committing on the next edge, announced by the bus task
  bit          pend = 1'b0;
  bit          pend_wr;
  logic [9:0]  pend_off;
  logic [31:0] pend_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [9:0] off);
    case (off)
      10'd0:   return {29'd0, m_ie, m_rel, m_en};
      10'd1:   return m_load;
      10'd2:   return m_count;
      10'd3:   return {31'd0, m_exp};
      10'd4:   return {29'd0, m_sw, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_rel = 0; m_ie = 0; m_exp = 0;
    m_load = '0; m_count = '0; m_sw = '0;
    exp_dout = '0; exp_wrack = 0; exp_rdack = 0; exp_irq = '0;
    pend = 0;
  endtask

  // One clock edge of the spec's behaviour
  task automatic model_step();
    bit fire;
    exp_irq   = {m_sw, m_exp & m_ie};
    exp_wrack = pend && pend_wr;
    exp_rdack = pend && !pend_wr;
    exp_dout  = (pend && !pend_wr) ? model_read(pend_off) : 32'd0;
    fire = m_en && (m_count == 0);
    if (m_en) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_rel)   m_count = m_load;
      else              m_en = 0;
    end
    if (pend && pend_wr) begin
      case (pend_off)
        10'd0: begin m_en = pend_data[0]; m_rel = pend_data[1]; m_ie = pend_data[2]; end
        10'd1: begin m_load = pend_data; m_count = pend_data; end
        10'd3: if (pend_data[0]) m_exp = 0;
        10'd4: m_sw = pend_data[2:1];
        default: ;
      endcase
    end
    if (fire) m_exp = 1;
    pend = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    cyc++;
    if (nReset) model_step();
    else model_reset();
  endtask

  // Compare process: every output, every cycle
  always @(negedge Clk) begin
    check("DataOut", DataOut, exp_dout);
    check("WRAck", {31'd0, WRAck}, {31'd0, exp_wrack});
    check("RDAck", {31'd0, RDAck}, {31'd0, exp_rdack});
    check("Interrupt", {29'd0, Interrupt}, {29'd0, exp_irq});
    if (WRAck) n_wrack++;
    if (RDAck) n_rdack++;
  end

  // Called #1 after an edge; returns #1 after the edge following the ack cycle
  task automatic bus(input bit we, input bit rd, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output int commit_c);
    int w;
    w = we ? int'(WRW) : int'(RDW);
    WE = we; RD = rd; Addr = a; DataIn = d;
    for (int i = 0; i < w; i++) tick();
    pend = 1; pend_wr = we; pend_off = a[11:2]; pend_data = d;
    tick();
    commit_c = cyc;
    #1 rdata = DataOut;
    tick();
    #1;
    WE = 0; RD = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int commit_c);
    logic [31:0] unused_rd;
    bus(1'b1, 1'b0, a, d, unused_rd, commit_c);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    int unused_c;
    bus(1'b0, 1'b1, a, 32'd0, v, unused_c);
  endtask

  // Cycle number of the edge where Interrupt[0] is first seen high, -1 on timeout
  task automatic wait_irq0(output int rc);
    rc = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      #1;
      if (Interrupt[0]) begin
        rc = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int c, c2, r1, r2, cw, cr;

    model_reset();
    // Read held across reset release
    RD = 1; Addr = A_COUNT;
    repeat (3) tick();
    #1 nReset = 1;
    cr = n_rdack;
    rd(A_COUNT, v);
    check("rst_read_data", v, 32'd0);
    repeat (4) tick();
    #1;
    check("rst_rdack_count", n_rdack - cr, 1);

    // Auto-reload timer
    wr(A_LOAD, 32'd5, c);
    wr(A_CTRL, 32'h7, c);
    wait_irq0(r1);
    check("irq_rise_delay", r1 - c, 7);
    rd(A_STATUS, v);
    check("status_expired", v, 32'd1);
    wr(A_STATUS, 32'd1, c2);
    wait_irq0(r2);
    check("reload_period", r2 - r1, 6);
    wr(A_CTRL, 32'h0, c);

    // One-shot timer
    wr(A_STATUS, 32'd1, c);
    wr(A_LOAD, 32'd3, c);
    wr(A_CTRL, 32'h5, c);
    repeat (10) tick();
    #1;
    check("oneshot_irq_high", {31'd0, Interrupt[0]}, 32'd1);
    rd(A_CTRL, v);
    check("oneshot_ctrl", v, 32'h4);
    rd(A_COUNT, v);
    check("oneshot_count", v, 32'd0);
    wr(A_STATUS, 32'd1, c);
    check("status_clear_irq", {31'd0, Interrupt[0]}, 32'd0);

    // Software interrupts
    wr(A_SWIRQ, 32'h7, c);
    check("swirq_irq", {30'd0, Interrupt[2:1]}, 32'd3);
    rd(A_SWIRQ, v);
    check("swirq_read", v, 32'h6);

    // Clear-write landing on the expiry edge
    wr(A_CTRL, 32'h0, c);
    wr(A_STATUS, 32'd1, c);
    wr(A_LOAD, 32'd4, c);
    wr(A_CTRL, 32'h7, c);
    while (cyc < c + 4) tick();
    #1;
    wr(A_STATUS, 32'd1, c2);
    rd(A_STATUS, v);
    check("set_beats_clear", v, 32'd1);
    wr(A_CTRL, 32'h0, c);

    // Out-of-window write is never acked
    cw = n_wrack;
    WE = 1; Addr = 32'h20001000; DataIn = 32'h55;
    repeat (20) tick();
    #1 WE = 0;
    check("oow_no_ack", n_wrack - cw, 0);
    rd(A_LOAD, v);
    check("oow_load_kept", v, 32'd4);

    // WE and RD together: write wins
    cw = n_wrack; cr = n_rdack;
    bus(1'b1, 1'b1, A_LOAD, 32'hAA, v, c);
    repeat (3) tick();
    #1;
    check("both_wrack", n_wrack - cw, 1);
    check("both_no_rdack", n_rdack - cr, 0);
    rd(A_LOAD, v);
    check("both_load", v, 32'hAA);

    // Reset pulse during a read's wait state
    cr = n_rdack;
    RD = 1; Addr = A_CTRL;
    tick();
    #1 nReset = 0;
    model_reset();
    RD = 0;
    #1;
    check("rst_dataout", DataOut, 32'd0);
    check("rst_acks", {30'd0, WRAck, RDAck}, 32'd0);
    check("rst_irq", {29'd0, Interrupt}, 32'd0);
    repeat (2) tick();
    #1 nReset = 1;
    repeat (4) tick();
    #1;
    check("rst_abort_no_ack", n_rdack - cr, 0);
    rd(A_SWIRQ, v);
    check("rst_swirq", v, 32'd0);
    rd(A_LOAD, v);
    check("rst_load", v, 32'd0);

    repeat (2) tick();
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
